mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Parametrised successor of the single-cycle MEM stage: a multi-cycle load/store unit.
- Accepts one memory-stage op per handshake.
- Drives a valid/ready data-memory bus with byte strobes, waits for the response, then sign/zero-extends load data.
- Selects the register-file writeback value from load data, ALU result or PC+4.
- Sits between EX and WB of the ysyx22041405 core and owns the data-memory write path the old stage left unimplemented.

Parameters:
- WIDTH, 32, datapath/address width; legal values 32 or 64.
- STRB_W, WIDTH/8, derived; byte-strobe width; not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  unit can accept an op
- alu_result  in  WIDTH  effective address / ALU writeback value
- pc_add4  in  WIDTH  PC+4 writeback value
- rf_rs2  in  WIDTH  store data (low bytes used)
- dm_re  in  1  op is a load
- dm_we  in  1  op is a store (dm_re and dm_we both high is illegal; treated as store)
- dm_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword legal only when WIDTH=64)
- dm_unsigned  in  1  zero-extend the load
- wb_sel  in  2  0=alu_result, 1=load data, 2=pc_add4, 3=zero
- out_valid  out  1  result valid toward WB
- out_ready  in  1  WB accepts the result
- rf_wdata  out  WIDTH  writeback value
- out_misalign  out  1  the completed op was misaligned
- dm_req_valid  out  1  bus request valid
- dm_req_ready  in  1  bus accepts the request
- dm_addr  out  WIDTH  address aligned down to STRB_W
- dm_req_we  out  1  request is a write
- dm_wdata  out  WIDTH  lane-aligned store data
- dm_wstrb  out  STRB_W  byte write strobes; all zero for reads
- dm_resp_valid  in  1  response/ack valid
- dm_rdata  in  WIDTH  read data

Behaviour:
- Interface (decided): single clock clk, rising edge; rst synchronous and active-low.
- rst=0 at a clk edge forces state IDLE, even mid-transaction. Reset values: in_ready=1; out_valid, dm_req_valid, dm_req_we, out_misalign=0; dm_addr, dm_wdata, dm_wstrb, rf_wdata=0.
- A dm_resp_valid arriving in IDLE or DONE (e.g. a stale response after reset) is ignored.
- in_ready=1 only in IDLE. Inputs are registered on the in_valid&&in_ready edge.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> DONE: accepted op with dm_re=dm_we=0, or a misaligned access. Result is valid the next cycle (1-cycle latency).
  - IDLE -> REQ: accepted aligned load/store. dm_req_valid=1 in REQ; address, data, strobes and we stay stable until dm_req_ready.
  - REQ -> WAIT: on dm_req_valid&&dm_req_ready. dm_req_valid drops the next cycle.
  - WAIT -> DONE: on dm_resp_valid. Loads capture dm_rdata. Store acks ignore dm_rdata.
  - A response is never accepted in the same cycle as the request handshake; it is only sampled in WAIT.
  - DONE: out_valid=1, rf_wdata and out_misalign stable. DONE -> IDLE on out_ready.
- Minimum load/store latency is 3 cycles after acceptance (REQ, WAIT, DONE) when req_ready=1 and the response arrives on the first WAIT cycle.
- off = addr[log2(STRB_W)-1:0].
- dm_wstrb = ((1<<(1<<dm_size))-1) << off.
- dm_wdata = rs2 low (8<<dm_size) bits replicated across all lanes.
- Load: shift dm_rdata right by off*8, keep (8<<dm_size) bits, then sign- or zero-extend to WIDTH. Word loads with WIDTH=32 are not extended.
- Misaligned: half with off[0]≠0; word with off[1:0]≠0; dword with off[2:0]≠0.
- dm_size=3 with WIDTH=32 is treated as word.
- wb_sel=1 on a non-load op yields 0.

Optional Feature:
- Macro MEM_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned load/store issues no bus request. The op goes IDLE->DONE with out_misalign=1 and rf_wdata=0.
- Undefined: no misalignment detection and out_misalign is tied 0. The access is issued with off forced to the natural alignment of dm_size (low bits cleared), i.e. it is silently aligned down.

Test Plan:
- Store word, WIDTH=32, addr=0x8000_0004, rs2=0xDEADBEEF, req_ready=1 -> dm_addr=0x8000_0004, dm_wstrb=4'b1111, dm_wdata=0xDEADBEEF; ack after 2 WAIT cycles -> out_valid asserted 4 cycles after acceptance.
- Signed byte load, addr=0x8000_0003, dm_rdata=0x80FF_1234 -> dm_wstrb=0, rf_wdata=0xFFFF_FF80. Same op with dm_unsigned=1 -> 0x0000_0080.
- WIDTH=64 half store at addr=0x1006, rs2=0xABCD -> dm_addr=0x1000, dm_wstrb=8'b1100_0000, dm_wdata=0xABCD_ABCD_ABCD_ABCD.
- Backpressure: dm_req_ready=0 for 5 cycles, then out_ready=0 for 3 cycles -> request fields stable throughout; in_ready=0 until the cycle after out_ready=1.
- Non-memory op with wb_sel=2, pc_add4=0x8000_0010 -> out_valid next cycle, rf_wdata=0x8000_0010, no dm_req_valid.
- rst=0 in WAIT, then dm_resp_valid=1 in IDLE -> state IDLE, no out_valid. With MEM_LSU_MISALIGN_TRAP_EN, word load at 0x2 -> no request, out_misalign=1, rf_wdata=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store unit between EX and WB.
// Takes one memory-stage op per in_valid/in_ready handshake. It drives a
// valid/ready data-memory bus with byte strobes and waits for the response.
// It then extends the load data and selects the register-file writeback value.
// Optional build macro MEM_LSU_MISALIGN_TRAP_EN: when defined, a misaligned
// load/store skips the bus and completes with out_misalign=1 and rf_wdata=0.
// When it is undefined, a misaligned access is silently aligned down.
module mem_lsu #(
    parameter int WIDTH  = 32,
    parameter int STRB_W = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [WIDTH-1:0]  pc_add4,
    input  logic [WIDTH-1:0]  rf_rs2,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic              dm_unsigned,
    input  logic [1:0]        wb_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              out_misalign,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [WIDTH-1:0]  dm_addr,
    output logic              dm_req_we,
    output logic [WIDTH-1:0]  dm_wdata,
    output logic [STRB_W-1:0] dm_wstrb,
    input  logic              dm_resp_valid,
    input  logic [WIDTH-1:0]  dm_rdata
);
    localparam int OFF_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic              accept, is_mem, is_load, trap;
    logic [1:0]        size_eff;
    logic [OFF_W-1:0]  off_raw, size_mask, off_use;
    logic [7:0]        base_strb;
    logic [STRB_W-1:0] wstrb_c;
    logic [WIDTH-1:0]  wdata_c, direct_c, addr_al;

    // context of the accepted op, needed when the response arrives
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_uns, r_load_wb;
    logic [WIDTH-1:0]  r_direct;

    logic [WIDTH-1:0]  shifted, ld_mask, ld_ext;
    logic              ld_sign;

    assign in_ready     = (state == IDLE);
    assign dm_req_valid = (state == REQ);
    assign out_valid    = (state == DONE);
    assign accept       = in_valid && in_ready;

    // both strobes high is treated as a store
    assign is_mem   = dm_re | dm_we;
    assign is_load  = dm_re & ~dm_we;
    // a dword request on the 32-bit datapath behaves as a word
    assign size_eff = (WIDTH == 32 && dm_size == 2'd3) ? 2'd2 : dm_size;
    assign off_raw  = alu_result[OFF_W-1:0];
    assign addr_al  = {alu_result[WIDTH-1:OFF_W], {OFF_W{1'b0}}};

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign trap    = is_mem && ((off_raw & size_mask) != '0);
    assign off_use = off_raw;
`else
    assign trap    = 1'b0;
    assign off_use = off_raw & ~size_mask;
`endif

    assign wstrb_c = STRB_W'(base_strb) << off_use;

    // per-size decode: alignment mask, strobe pattern, replicated store data, direct result
    always_comb begin
        size_mask = '0;
        base_strb = 8'h01;
        wdata_c   = {STRB_W{rf_rs2[7:0]}};
        case (size_eff)
            2'd1: begin
                size_mask = OFF_W'(1);
                base_strb = 8'h03;
                wdata_c   = {(STRB_W/2){rf_rs2[15:0]}};
            end
            2'd2: begin
                size_mask = OFF_W'(3);
                base_strb = 8'h0F;
                wdata_c   = {(STRB_W/4){rf_rs2[31:0]}};
            end
            2'd3: begin
                size_mask = OFF_W'(7);
                base_strb = 8'hFF;
                wdata_c   = rf_rs2;
            end
            default: ;
        endcase
        case (wb_sel)
            2'd0:    direct_c = alu_result;
            2'd2:    direct_c = pc_add4;
            default: direct_c = '0;
        endcase
    end

    // load lane extraction and sign/zero extension from the registered context
    always_comb begin
        shifted = dm_rdata >> {r_off, 3'b000};
        ld_mask = '1;
        ld_sign = 1'b0;
        case (r_size)
            2'd0: begin ld_mask = WIDTH'(64'hFF);        ld_sign = shifted[7];  end
            2'd1: begin ld_mask = WIDTH'(64'hFFFF);      ld_sign = shifted[15]; end
            2'd2: begin ld_mask = WIDTH'(64'hFFFF_FFFF); ld_sign = shifted[31]; end
            default: ;
        endcase
        ld_ext = (shifted & ld_mask) | ((!r_uns && ld_sign) ? ~ld_mask : '0);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state: bus-less ops skip straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (!is_mem || trap) ? DONE : REQ;
            REQ:  if (dm_req_ready) state_nxt = WAIT;
            WAIT: if (dm_resp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // datapath: capture the op on accept, the result on the response
    always_ff @(posedge clk) begin
        if (!rst) begin
            dm_addr      <= '0;
            dm_wdata     <= '0;
            dm_wstrb     <= '0;
            dm_req_we    <= 1'b0;
            rf_wdata     <= '0;
            out_misalign <= 1'b0;
            r_off        <= '0;
            r_size       <= '0;
            r_uns        <= 1'b0;
            r_load_wb    <= 1'b0;
            r_direct     <= '0;
        end else begin
            if (accept) begin
                r_off        <= off_use;
                r_size       <= size_eff;
                r_uns        <= dm_unsigned;
                r_load_wb    <= is_load && (wb_sel == 2'd1);
                r_direct     <= direct_c;
                out_misalign <= trap;
                if (!is_mem || trap) rf_wdata <= trap ? '0 : direct_c;
                if (is_mem && !trap) begin
                    dm_addr   <= addr_al;
                    dm_req_we <= dm_we;
                    dm_wdata  <= dm_we ? wdata_c : '0;
                    dm_wstrb  <= dm_we ? wstrb_c : '0;
                end
            end
            if (state == WAIT && dm_resp_valid)
                rf_wdata <= r_load_wb ? ld_ext : r_direct;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: runs a 32-bit and a 64-bit mem_lsu one op at a time.
// Expected bus fields and results come from an arithmetic model of the op.
// A per-cycle compare process checks the handshakes against the timeline
// that the driver schedules.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid32, in_valid64;
    logic [63:0] alu_result, pc_add4, rf_rs2, dm_rdata;
    logic        dm_re, dm_we, dm_unsigned, out_ready, dm_req_ready, dm_resp_valid;
    logic [1:0]  dm_size, wb_sel;

    logic        in_ready32, out_valid32, mis32, reqv32, reqwe32;
    logic [31:0] rfw32, addr32, wdata32;
    logic [3:0]  wstrb32;
    logic        in_ready64, out_valid64, mis64, reqv64, reqwe64;
    logic [63:0] rfw64, addr64, wdata64;
    logic [7:0]  wstrb64;

    always #5 clk = ~clk;

    mem_lsu #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .alu_result(alu_result[31:0]), .pc_add4(pc_add4[31:0]), .rf_rs2(rf_rs2[31:0]),
        .dm_re(dm_re), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
        .wb_sel(wb_sel), .out_valid(out_valid32), .out_ready(out_ready),
        .rf_wdata(rfw32), .out_misalign(mis32), .dm_req_valid(reqv32),
        .dm_req_ready(dm_req_ready), .dm_addr(addr32), .dm_req_we(reqwe32),
        .dm_wdata(wdata32), .dm_wstrb(wstrb32), .dm_resp_valid(dm_resp_valid),
        .dm_rdata(dm_rdata[31:0]));

    mem_lsu #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .alu_result(alu_result), .pc_add4(pc_add4), .rf_rs2(rf_rs2),
        .dm_re(dm_re), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
        .wb_sel(wb_sel), .out_valid(out_valid64), .out_ready(out_ready),
        .rf_wdata(rfw64), .out_misalign(mis64), .dm_req_valid(reqv64),
        .dm_req_ready(dm_req_ready), .dm_addr(addr64), .dm_req_we(reqwe64),
        .dm_wdata(wdata64), .dm_wstrb(wstrb64), .dm_resp_valid(dm_resp_valid),
        .dm_rdata(dm_rdata));

    // view of the DUT under test (sel64) and the idle one
    bit          sel64;
    logic        a_rdy, a_reqv, a_outv, a_we, a_mis, o_reqv, o_outv;
    logic [63:0] a_addr, a_wdata, a_res;
    logic [7:0]  a_wstrb;
    assign a_rdy   = sel64 ? in_ready64  : in_ready32;
    assign a_reqv  = sel64 ? reqv64      : reqv32;
    assign a_outv  = sel64 ? out_valid64 : out_valid32;
    assign a_we    = sel64 ? reqwe64     : reqwe32;
    assign a_mis   = sel64 ? mis64       : mis32;
    assign a_addr  = sel64 ? addr64      : {32'h0, addr32};
    assign a_wdata = sel64 ? wdata64     : {32'h0, wdata32};
    assign a_res   = sel64 ? rfw64       : {32'h0, rfw32};
    assign a_wstrb = sel64 ? wstrb64     : {4'h0, wstrb32};
    assign o_reqv  = sel64 ? reqv32      : reqv64;
    assign o_outv  = sel64 ? out_valid32 : out_valid64;

    // expectations scheduled by the driver
    bit          chk_en, e_rdy, e_req, e_out;
    logic [63:0] ex_addr, ex_wdata, ex_res;
    logic [7:0]  ex_wstrb;
    logic        ex_we, ex_mis;
    int          acc_cyc;
    // literal pins posted by the driver, checked by the compare process
    bit          pin_valid;
    string       pin_name;
    logic [63:0] pin_act, pin_exp;

    // owned by the compare process
    int          checks = 0, errors = 0, cyc = 0, first_out_cyc = 0;
    logic        prev_outv = 1'b0;
    logic [63:0] cap_addr, cap_wdata, cap_res;
    logic [7:0]  cap_wstrb;
    logic        cap_mis;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // compare process: every cycle, DUT against the scheduled model
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("in_ready", 64'(a_rdy), 64'(e_rdy));
            chk("req_valid", 64'(a_reqv), 64'(e_req));
            chk("out_valid", 64'(a_outv), 64'(e_out));
            chk("other_req_valid", 64'(o_reqv), 64'd0);
            chk("other_out_valid", 64'(o_outv), 64'd0);
            if (e_req && a_reqv) begin
                chk("dm_addr", a_addr, ex_addr);
                chk("dm_req_we", 64'(a_we), 64'(ex_we));
                chk("dm_wstrb", 64'(a_wstrb), 64'(ex_wstrb));
                if (ex_we) chk("dm_wdata", a_wdata, ex_wdata);
                cap_addr = a_addr; cap_wdata = a_wdata; cap_wstrb = a_wstrb;
            end
            if (e_out && a_outv) begin
                chk("rf_wdata", a_res, ex_res);
                chk("out_misalign", 64'(a_mis), 64'(ex_mis));
                cap_res = a_res; cap_mis = a_mis;
            end
            if (pin_valid) chk(pin_name, pin_act, pin_exp);
        end
        if (a_outv && !prev_outv) first_out_cyc = cyc;
        prev_outv = a_outv;
    end

    task automatic pin(input string nm, input logic [63:0] act, input logic [63:0] exp);
        pin_name = nm; pin_act = act; pin_exp = exp; pin_valid = 1'b1;
        @(negedge clk); #1;
        pin_valid = 1'b0;
    endtask

    // model of one op: bus fields, writeback value and whether the bus is used
    task automatic model(input int w, input logic [63:0] alu, pc, rs2, rdata,
                         input logic re, we, uns, input logic [1:0] size, wsel,
                         output bit req);
        int sz, nb, sb, off;
        logic [63:0] wm, lm, v;
        bit trap;
        sz = (w == 32 && size == 2'd3) ? 2 : int'(size);
        nb = 1 << sz;
        sb = w / 8;
        wm = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        lm = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
        off = int'(alu % 64'(sb));
        trap = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap = (re || we) && (off % nb != 0);
`else
        off = off - off % nb;
`endif
        req      = (re || we) && !trap;
        ex_we    = we;
        ex_mis   = trap;
        ex_addr  = (alu & wm) - (alu % 64'(sb));
        ex_wstrb = we ? 8'(((1 << nb) - 1) << off) : 8'h00;
        ex_wdata = 64'h0;
        if (we) for (int i = 0; i < sb / nb; i++) ex_wdata |= (rs2 & lm) << (i * nb * 8);
        v = ((rdata & wm) >> (off * 8)) & lm;
        if (!uns && v[nb*8-1]) v |= ~lm;
        v &= wm;
        if (trap) ex_res = 64'h0;
        else case (wsel)
            2'd0:    ex_res = alu & wm;
            2'd1:    ex_res = (re && !we) ? v : 64'h0;
            2'd2:    ex_res = pc & wm;
            default: ex_res = 64'h0;
        endcase
    endtask

    task automatic scramble(input bit w64);
        alu_result = {$urandom, $urandom}; pc_add4 = {$urandom, $urandom};
        rf_rs2 = {$urandom, $urandom}; dm_size = 2'($urandom);
        dm_re = 1'($urandom); dm_we = 1'($urandom); dm_unsigned = 1'($urandom);
        wb_sel = 2'($urandom);
        if (w64) in_valid64 = 1'($urandom); else in_valid32 = 1'($urandom);
    endtask

    // one op from acceptance to writeback with the given stall counts
    task automatic run_op(input bit w64, input logic [63:0] alu, pc, rs2, rdata,
                          input logic re, we, uns, input logic [1:0] size, wsel,
                          input int rd, wd, od);
        bit req;
        model(w64 ? 64 : 32, alu, pc, rs2, rdata, re, we, uns, size, wsel, req);
        sel64 = w64;
        alu_result = alu; pc_add4 = pc; rf_rs2 = rs2; dm_re = re; dm_we = we;
        dm_unsigned = uns; dm_size = size; wb_sel = wsel;
        if (w64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
        dm_resp_valid = 1'($urandom);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid32 = 1'b0; in_valid64 = 1'b0;
        scramble(w64);
        e_rdy = 1'b0;
        if (req) begin
            e_req = 1'b1;
            for (int i = 0; i < rd; i++) begin
                dm_req_ready = 1'b0; dm_resp_valid = 1'($urandom); scramble(w64);
                @(posedge clk); #1;
            end
            dm_req_ready = 1'b1; dm_resp_valid = 1'($urandom);
            @(posedge clk); #1;
            e_req = 1'b0; dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
            for (int i = 0; i < wd; i++) begin scramble(w64); @(posedge clk); #1; end
            dm_resp_valid = 1'b1; dm_rdata = rdata;
            @(posedge clk); #1;
            dm_resp_valid = 1'b0; dm_rdata = {$urandom, $urandom};
        end
        e_out = 1'b1;
        for (int i = 0; i < od; i++) begin
            out_ready = 1'b0; dm_resp_valid = 1'($urandom); scramble(w64);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; e_out = 1'b0; e_rdy = 1'b1; dm_resp_valid = 1'b0;
        in_valid32 = 1'b0; in_valid64 = 1'b0;
    endtask

    initial begin
        int v;
        rst = 1'b0; chk_en = 1'b0; sel64 = 1'b0; pin_valid = 1'b0;
        e_rdy = 1'b1; e_req = 1'b0; e_out = 1'b0;
        in_valid32 = 1'b0; in_valid64 = 1'b0; out_ready = 1'b0;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_rdata = '0;
        alu_result = '0; pc_add4 = '0; rf_rs2 = '0; dm_re = 1'b0; dm_we = 1'b0;
        dm_size = '0; dm_unsigned = 1'b0; wb_sel = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; chk_en = 1'b1;
        pin("rst_rf_wdata32", {32'h0, rfw32}, 64'h0);
        pin("rst_dm_wstrb64", 64'(wstrb64), 64'h0);

        // word store, ack on the second WAIT cycle
        run_op(0, 64'h8000_0004, 64'h0, 64'hDEAD_BEEF, 64'h0, 0, 1, 0, 2'd2, 2'd0, 0, 1, 0);
        pin("sw_addr", cap_addr, 64'h8000_0004);
        pin("sw_wstrb", 64'(cap_wstrb), 64'hF);
        pin("sw_wdata", cap_wdata, 64'hDEAD_BEEF);
        pin("sw_latency", 64'(first_out_cyc - acc_cyc), 64'd4);
        // signed and unsigned byte loads
        run_op(0, 64'h8000_0003, 64'h0, 64'h0, 64'h80FF_1234, 1, 0, 0, 2'd0, 2'd1, 0, 0, 0);
        pin("lb_wstrb", 64'(cap_wstrb), 64'h0);
        pin("lb_res", cap_res, 64'hFFFF_FF80);
        pin("lb_latency", 64'(first_out_cyc - acc_cyc), 64'd3);
        run_op(0, 64'h8000_0003, 64'h0, 64'h0, 64'h80FF_1234, 1, 0, 1, 2'd0, 2'd1, 0, 0, 0);
        pin("lbu_res", cap_res, 64'h80);
        // 64-bit half store in the top lanes
        run_op(1, 64'h1006, 64'h0, 64'hABCD, 64'h0, 0, 1, 0, 2'd1, 2'd0, 0, 0, 0);
        pin("sh64_addr", cap_addr, 64'h1000);
        pin("sh64_wstrb", 64'(cap_wstrb), 64'hC0);
        pin("sh64_wdata", cap_wdata, 64'hABCD_ABCD_ABCD_ABCD);
        // request and writeback backpressure
        run_op(0, 64'h8000_0008, 64'h0, 64'h1234_5678, 64'h0, 0, 1, 0, 2'd2, 2'd0, 5, 0, 3);
        // non-memory op returning pc+4
        run_op(0, 64'h55, 64'h8000_0010, 64'h0, 64'h0, 0, 0, 0, 2'd0, 2'd2, 0, 0, 0);
        pin("pc4_res", cap_res, 64'h8000_0010);
        pin("pc4_latency", 64'(first_out_cyc - acc_cyc), 64'd1);

        // reset in WAIT with a response arriving at the reset edge and in IDLE
        sel64 = 1'b0;
        alu_result = 64'h40; dm_re = 1'b1; dm_we = 1'b0; dm_size = 2'd2; wb_sel = 2'd1;
        in_valid32 = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b0; e_rdy = 1'b0; e_req = 1'b1; ex_addr = 64'h40; ex_we = 1'b0; ex_wstrb = 8'h0;
        dm_req_ready = 1'b1;
        @(posedge clk); #1;
        dm_req_ready = 1'b0; e_req = 1'b0;
        rst = 1'b0; dm_resp_valid = 1'b1; dm_rdata = 64'h1357_9BDF;
        @(posedge clk); #1;
        rst = 1'b1; e_rdy = 1'b1;
        @(posedge clk); #1;
        dm_resp_valid = 1'b0;
        pin("rst_dm_addr", {32'h0, addr32}, 64'h0);
        pin("rst_rf_wdata", {32'h0, rfw32}, 64'h0);

        // word load at 0x2
        run_op(0, 64'h2, 64'h0, 64'h0, 64'h1122_3344, 1, 0, 0, 2'd2, 2'd1, 0, 0, 0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        pin("mis_flag", 64'(cap_mis), 64'd1);
        pin("mis_res", cap_res, 64'h0);
        pin("mis_latency", 64'(first_out_cyc - acc_cyc), 64'd1);
`else
        pin("mis_flag", 64'(cap_mis), 64'd0);
        pin("mis_res", cap_res, 64'h1122_3344);
        pin("mis_addr", cap_addr, 64'h0);
`endif

        // randomized ops on both widths
        for (int n = 0; n < 200; n++) begin
            v = int'($urandom % 4);
            run_op(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom}, v[0], v[1], 1'($urandom),
                   2'($urandom), 2'($urandom), int'($urandom % 4), int'($urandom % 3),
                   int'($urandom % 3));
        end

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
